// File: rtl/ntt_pkg.sv
// Shared NTT datapath definitions: default word/modulus, butterfly mode and
// the modular add/sub helpers reused by every butterfly stage.
package ntt_pkg;

  localparam int          W_DEFAULT = 28;
  localparam logic [63:0] Q_DEFAULT = 64'd268369921;  // 2^28 - 2^16 + 1

  typedef enum logic {
    MODE_CT = 1'b0,
    MODE_GS = 1'b1
  } mode_e;

  // Operands are zero-extended to 64 bits by the caller, so a + b never
  // overflows for any W up to 63.
  function automatic logic [63:0] mod_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic [63:0] q);
    logic [63:0] s;
    s = a + b;
    return (s >= q) ? s - q : s;
  endfunction

  function automatic logic [63:0] mod_sub(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic [63:0] q);
    return (a < b) ? a - b + q : a - b;
  endfunction

endpackage

// File: rtl/ntt_modmul_pipe.sv
// Fully pipelined a*b mod Q with a valid pass-through; result appears
// MUL_LAT cycles after the operands are presented.
module ntt_modmul_pipe
  import ntt_pkg::*;
#(
  parameter int          W       = W_DEFAULT,
  parameter logic [W-1:0] Q      = W'(Q_DEFAULT),
  parameter int          MUL_LAT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  output logic [W-1:0] p,
  output logic         busy
);

  logic [2*W-1:0]     prod;
  logic [W-1:0]       red;
  logic [MUL_LAT-1:0] vld;
  logic [W-1:0]       data [MUL_LAT];

  // The reduction sits in front of the register chain; retiming is expected
  // to spread it across the MUL_LAT stages.
  assign prod = (2*W)'(a) * (2*W)'(b);
  assign red  = W'(prod % (2*W)'(Q));

  // NOTE: state registers use non-blocking assignments so every stage samples
  // the previous stage's old value on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      // NOTE: this array is a shift chain, not a RAM, so it is reset
      // element by element to keep outputs at zero during reset.
      for (int i = 0; i < MUL_LAT; i++) data[i] <= '0;
    end else begin
      vld[0]  <= in_valid;
      data[0] <= red;
      for (int i = 1; i < MUL_LAT; i++) begin
        vld[i]  <= vld[i-1];
        data[i] <= data[i-1];
      end
    end
  end

  assign out_valid = vld[MUL_LAT-1];
  assign p         = data[MUL_LAT-1];
  assign busy      = |vld;

endmodule

// File: rtl/ntt_butterfly_pipe.sv
// Run-time selectable CT/GS modular butterfly with a built-in twiddle
// sequencer; fixed latency MUL_LAT+2 in both modes.
module ntt_butterfly_pipe
  import ntt_pkg::*;
#(
  parameter int                    W       = W_DEFAULT,
  parameter logic [W-1:0]          Q       = W'(Q_DEFAULT),
  parameter int                    NTW     = 16,
  parameter logic [NTW-1:0][W-1:0] TW      = '1,
  parameter int                    START   = 6,
  parameter int                    STEP    = 1,
  parameter int                    MUL_LAT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] y_in,
  input  logic         mode,
  input  logic         tw_restart,
  output logic         out_valid,
  output logic [W-1:0] x_out,
  output logic [W-1:0] y_out,
  output logic         busy
);

  localparam int IW = $clog2(NTW);

  mode_e         mode_reg;
  logic [31:0]   pre_cnt, pre_base;
  logic [IW-1:0] step_idx, step_base, idx_now;
  logic          pre_phase;

  logic          v_a, v_b, v_c;
  logic [W-1:0]  x_a, y_a, sum_b, dif_b, add_c, sub_c;
  logic [IW-1:0] idx_a, idx_b;

  logic          mul_in_v, mul_out_v, mul_busy;
  logic [W-1:0]  mul_a, mul_b, mul_p;
  logic [W-1:0]  dly [MUL_LAT];
  logic [W-1:0]  dly_in, dly_out;

  assign busy = v_a | v_b | mul_busy | v_c | out_valid;

  // A restart in the same cycle as a sample makes that sample n=0.
  assign pre_base  = tw_restart ? '0 : pre_cnt;
  assign step_base = tw_restart ? '0 : step_idx;
  assign pre_phase = pre_base < 32'(START);
  assign idx_now   = pre_phase ? '0 : step_base;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt  <= '0;
      step_idx <= '0;
    end else begin
      pre_cnt  <= pre_base;
      step_idx <= step_base;
      if (in_valid) begin
        if (pre_phase) pre_cnt  <= pre_base + 32'd1;
        else           step_idx <= step_base + IW'(STEP);
      end
    end
  end

  // Mode is frozen while anything is in flight, so CT and GS samples never
  // meet at the shared multiplier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_reg <= MODE_CT;
      v_a      <= 1'b0;
      x_a      <= '0;
      y_a      <= '0;
      idx_a    <= '0;
      v_b      <= 1'b0;
      sum_b    <= '0;
      dif_b    <= '0;
      idx_b    <= '0;
    end else begin
      if (!busy) mode_reg <= mode_e'(mode);
      v_a <= in_valid;
      if (in_valid) begin
        x_a   <= x_in;
        y_a   <= y_in;
        idx_a <= idx_now;
      end
      v_b <= v_a && (mode_reg == MODE_GS);
      if (v_a) begin
        sum_b <= W'(mod_add(64'(x_a), 64'(y_a), 64'(Q)));
        dif_b <= W'(mod_sub(64'(x_a), 64'(y_a), 64'(Q)));
        idx_b <= idx_a;
      end
    end
  end

  // CT feeds the multiplier one stage earlier than GS; the GS add/sub stage
  // fills that gap so both modes share the same latency.
  // NOTE: every branch assigns every signal, so no latch is inferred.
  always_comb begin
    if (mode_reg == MODE_CT) begin
      mul_in_v = v_a;
      mul_a    = y_a;
      mul_b    = TW[idx_a];
      dly_in   = x_a;
    end else begin
      mul_in_v = v_b;
      mul_a    = dif_b;
      mul_b    = TW[idx_b];
      dly_in   = sum_b;
    end
  end

  ntt_modmul_pipe #(
    .W       (W),
    .Q       (Q),
    .MUL_LAT (MUL_LAT)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (mul_in_v),
    .a         (mul_a),
    .b         (mul_b),
    .out_valid (mul_out_v),
    .p         (mul_p),
    .busy      (mul_busy)
  );

  assign dly_out = dly[MUL_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) dly[i] <= '0;
      v_c       <= 1'b0;
      add_c     <= '0;
      sub_c     <= '0;
      out_valid <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
    end else begin
      dly[0] <= dly_in;
      for (int i = 1; i < MUL_LAT; i++) dly[i] <= dly[i-1];
      v_c <= mul_out_v && (mode_reg == MODE_CT);
      if (mul_out_v) begin
        add_c <= W'(mod_add(64'(dly_out), 64'(mul_p), 64'(Q)));
        sub_c <= W'(mod_sub(64'(dly_out), 64'(mul_p), 64'(Q)));
      end
      if (mode_reg == MODE_CT) begin
        out_valid <= v_c;
        if (v_c) begin
          x_out <= add_c;
          y_out <= sub_c;
        end
      end else begin
        out_valid <= mul_out_v;
        if (mul_out_v) begin
          x_out <= dly_out;
          y_out <= mul_p;
        end
      end
    end
  end

endmodule

// File: tb/tb_ntt_butterfly_pipe.sv
// Directed bench for ntt_butterfly_pipe: three instances (CT w=1, w=2 for
// GS/mode gating, stepped twiddle table) sharing one clock and reset.
module tb_ntt_butterfly_pipe;

  localparam int W = 28;
  localparam int Q = 268369921;
  localparam int L = 6;

  function automatic logic [15:0][W-1:0] seq_tw();
    logic [15:0][W-1:0] t;
    for (int i = 0; i < 16; i++) t[i] = W'(i + 1);
    return t;
  endfunction
  localparam logic [15:0][W-1:0] TW_SEQ = seq_tw();

  // Reference twiddle for dut2: START=2, STEP=3, TW[i]=i+1.
  function automatic int tw_of(int n);
    int idx;
    idx = (n < 2) ? 0 : ((n - 2) * 3) % 16;
    return idx + 1;
  endfunction

  logic         clk = 1'b0;
  logic         rst;
  logic         iv [3];
  logic         md [3];
  logic         rs [3];
  logic [W-1:0] xi [3];
  logic [W-1:0] yi [3];
  logic         ov [3];
  logic         bz [3];
  logic [W-1:0] xo [3];
  logic [W-1:0] yo [3];

  always #5 clk = ~clk;

  ntt_butterfly_pipe #(.NTW(16), .TW({16{28'd1}}), .START(0), .STEP(1), .MUL_LAT(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .x_in(xi[0]), .y_in(yi[0]), .mode(md[0]),
    .tw_restart(rs[0]), .out_valid(ov[0]), .x_out(xo[0]), .y_out(yo[0]), .busy(bz[0]));

  ntt_butterfly_pipe #(.NTW(16), .TW({16{28'd2}}), .START(0), .STEP(1), .MUL_LAT(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .x_in(xi[1]), .y_in(yi[1]), .mode(md[1]),
    .tw_restart(rs[1]), .out_valid(ov[1]), .x_out(xo[1]), .y_out(yo[1]), .busy(bz[1]));

  ntt_butterfly_pipe #(.NTW(16), .TW(TW_SEQ), .START(2), .STEP(3), .MUL_LAT(4)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .x_in(xi[2]), .y_in(yi[2]), .mode(md[2]),
    .tw_restart(rs[2]), .out_valid(ov[2]), .x_out(xo[2]), .y_out(yo[2]), .busy(bz[2]));

  typedef struct {
    int k;
    int x;
    int y;
    int c;
  } obs_t;

  typedef struct {
    int k;
    bit m;
    int x;
    int y;
    int ex;
    int ey;
  } vec_t;

  obs_t oq [$];
  int   acc_q [$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl [9];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    for (int k = 0; k < 3; k++)
      if (ov[k]) oq.push_back('{k, int'(xo[k]), int'(yo[k]), cyc});

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic quiet();
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0;
      rs[k] = 1'b0;
    end
  endtask

  task automatic gap(int n);
    quiet();
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; the sample is accepted at the following posedge.
  task automatic drive(int k, bit v, int x, int y, bit m, bit r);
    iv[k] = v;
    xi[k] = W'(x);
    yi[k] = W'(y);
    md[k] = m;
    rs[k] = r;
    if (v) acc_q.push_back(cyc + 1);
    @(negedge clk);
  endtask

  task automatic wait_idle(int k);
    int b;
    b = 0;
    quiet();
    while (bz[k] && b < 60) begin
      @(negedge clk);
      b++;
    end
    check($sformatf("idle dut%0d", k), int'(bz[k]), 0);
  endtask

  task automatic drain(int n, string name);
    int b;
    b = 0;
    quiet();
    while (oq.size() < n && b < 100) begin
      @(negedge clk);
      b++;
    end
    check({name, " count"}, oq.size(), n);
  endtask

  task automatic expect_out(string name, int k, int ex, int ey);
    obs_t o;
    int   a;
    if (oq.size() == 0 || acc_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: actual no output, required (%0d,%0d)", name, ex, ey);
    end else begin
      o = oq.pop_front();
      a = acc_q.pop_front();
      check({name, " dut"}, o.k, k);
      check({name, " x"}, o.x, ex);
      check({name, " y"}, o.y, ey);
      check({name, " latency"}, o.c - a, L);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; xi[k] = '0; yi[k] = '0; md[k] = 1'b0; rs[k] = 1'b0;
    end
    @(negedge clk);
    check("reset out_valid", int'(ov[0]), 0);
    check("reset x_out", int'(xo[0]), 0);
    check("reset y_out", int'(yo[0]), 0);
    check("reset busy", int'(bz[0]), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single-sample vectors: {dut, mode, x, y, x_out, y_out}.
    tbl[0] = '{0, 1'b0, 5, 3, 8, 2};
    tbl[1] = '{0, 1'b0, 1, 3, 4, 268369919};
    tbl[2] = '{0, 1'b0, 268369920, 268369920, 268369919, 0};
    tbl[3] = '{0, 1'b0, 268369920, 1, 0, 268369919};
    tbl[4] = '{1, 1'b1, 5, 3, 8, 4};
    tbl[5] = '{1, 1'b1, 3, 5, 8, 268369917};
    tbl[6] = '{1, 1'b1, 268369920, 1, 0, 268369917};
    tbl[7] = '{1, 1'b1, 0, 268369920, 268369920, 2};
    tbl[8] = '{1, 1'b0, 7, 9, 25, 268369910};
    for (int i = 0; i < 9; i++) begin
      wait_idle(tbl[i].k);
      oq.delete();
      acc_q.delete();
      drive(tbl[i].k, 1'b1, tbl[i].x, tbl[i].y, tbl[i].m, 1'b0);
      drain(1, $sformatf("vec%0d", i));
      expect_out($sformatf("vec%0d", i), tbl[i].k, tbl[i].ex, tbl[i].ey);
    end

    // Twiddle sequencing on dut2 with x=0, y=1: y_out = Q - w.
    begin
      int exp_w [$];
      int n;
      wait_idle(2);
      oq.delete();
      acc_q.delete();
      n = 0;
      for (int i = 0; i < 10; i++) begin drive(2, 1'b1, 0, 1, 1'b0, 1'b0); exp_w.push_back(tw_of(n)); n++; end
      gap(3);
      for (int i = 0; i < 10; i++) begin drive(2, 1'b1, 0, 1, 1'b0, 1'b0); exp_w.push_back(tw_of(n)); n++; end
      gap(2);
      drive(2, 1'b0, 0, 0, 1'b0, 1'b1);
      n = 0;
      for (int i = 0; i < 3; i++) begin drive(2, 1'b1, 0, 1, 1'b0, 1'b0); exp_w.push_back(tw_of(n)); n++; end
      drive(2, 1'b1, 0, 1, 1'b0, 1'b1);
      n = 0;
      exp_w.push_back(tw_of(n)); n++;
      for (int i = 0; i < 3; i++) begin drive(2, 1'b1, 0, 1, 1'b0, 1'b0); exp_w.push_back(tw_of(n)); n++; end
      drain(exp_w.size(), "tw");
      for (int i = 0; i < exp_w.size(); i++)
        expect_out($sformatf("tw%0d", i), 2, exp_w[i], Q - exp_w[i]);
    end

    // Mode gating on dut1 (w=2): toggle to GS mid-stream, outputs stay CT.
    wait_idle(1);
    oq.delete();
    acc_q.delete();
    drive(1, 1'b1, 10, 3, 1'b0, 1'b0);
    drive(1, 1'b1, 20, 4, 1'b1, 1'b0);
    drive(1, 1'b1, 7, 9, 1'b1, 1'b0);
    drive(1, 1'b1, 100, 1, 1'b1, 1'b0);
    check("gate busy mid-stream", int'(bz[1]), 1);
    wait_idle(1);
    drain(4, "gate ct");
    expect_out("gate ct0", 1, 16, 4);
    expect_out("gate ct1", 1, 28, 12);
    expect_out("gate ct2", 1, 25, 268369910);
    expect_out("gate ct3", 1, 102, 98);
    drive(1, 1'b1, 5, 3, 1'b1, 1'b0);
    drive(1, 1'b1, 3, 5, 1'b1, 1'b0);
    drive(1, 1'b1, 268369920, 1, 1'b1, 1'b0);
    drain(3, "gate gs");
    expect_out("gate gs0", 1, 8, 4);
    expect_out("gate gs1", 1, 8, 268369917);
    expect_out("gate gs2", 1, 0, 268369917);

    // Asynchronous reset between edges with samples in flight on dut2.
    wait_idle(2);
    oq.delete();
    acc_q.delete();
    drive(2, 1'b1, 0, 1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) drive(2, 1'b1, 0, 1, 1'b0, 1'b0);
    check("pre-reset out_valid", int'(ov[2]), 1);
    iv[2] = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async rst out_valid", int'(ov[2]), 0);
    check("async rst busy", int'(bz[2]), 0);
    check("async rst x_out", int'(xo[2]), 0);
    check("async rst y_out", int'(yo[2]), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    oq.delete();
    acc_q.delete();
    gap(12);
    check("no output after reset", oq.size(), 0);
    for (int i = 0; i < 4; i++) drive(2, 1'b1, 0, 1, 1'b0, 1'b0);
    drain(4, "post-reset");
    for (int i = 0; i < 4; i++)
      expect_out($sformatf("post-reset%0d", i), 2, tw_of(i), Q - tw_of(i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
